freq_meas_sched: RTL

//   Shares one period-measurement counter among N_CH square-wave inputs, all timed against ref_clk.
//   On each start pulse it does one round-robin sweep over the enabled channels.
//   For each channel it arms on a rising edge, counts ref_clk cycles to the next rising edge, then

---
 rtl/freq_sched_pkg.sv | 19 +
 rtl/freq_meas_sched_sync.sv | 20 ++
 rtl/freq_meas_sched.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/freq_sched_pkg.sv
// freq_sched_pkg: FSM encoding, edge-detect depth and sizing helper for freq_meas_sched
package freq_sched_pkg;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SELECT  = 3'd1;
  localparam logic [2:0] ST_ARM     = 3'd2;
  localparam logic [2:0] ST_MEASURE = 3'd3;
  localparam logic [2:0] ST_REPORT  = 3'd4;
  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    SELECT  = ST_SELECT,
    ARM     = ST_ARM,
    MEASURE = ST_MEASURE,
    REPORT  = ST_REPORT
  } state_t;
  localparam int EDGE_DEPTH = 3;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/freq_meas_sched_sync.sv
// sq_edge_sync: 2-flop synchronizer plus edge register; level/rise/fall lag the input by EDGE_DEPTH cycles
module sq_edge_sync
  import freq_sched_pkg::*;
(
  input  logic ref_clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [EDGE_DEPTH:0] sh;
  always_ff @(posedge ref_clk) begin
    if (!rst_n) sh <= '0;
    else sh <= {sh[EDGE_DEPTH-1:0], d};
  end
  assign level = sh[EDGE_DEPTH-1];
  assign rise  = sh[EDGE_DEPTH-1] & ~sh[EDGE_DEPTH];
  assign fall  = ~sh[EDGE_DEPTH-1] & sh[EDGE_DEPTH];
endmodule

// File: rtl/freq_meas_sched.sv
// freq_meas_sched: round-robin period measurement of N_CH square waves with one shared counter
// FREQ_SCHED_DUTY_EN adds the res_high port and its high-time counter.
module freq_meas_sched
  import freq_sched_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic                         ref_clk,
  input  logic                         rst_n,
  input  logic [N_CH-1:0]              sq_wave,
  input  logic [N_CH-1:0]              ch_enable,
  input  logic                         start,
  output logic                         busy,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [clog2_min1(N_CH)-1:0]  res_ch,
  output logic [CNT_W-1:0]             res_period,
  output logic                         res_timeout
`ifdef FREQ_SCHED_DUTY_EN
  ,
  output logic [CNT_W-1:0]             res_high
`endif
);
  localparam int CH_W = clog2_min1(N_CH);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  state_t state;
  logic [N_CH-1:0] rise, mask, mask_left, pick_src;
  logic [CH_W-1:0] ptr, nxt_ptr;
  logic [CNT_W-1:0] pcnt, tcnt;
  logic sel_rise, tmo, hs;
`ifdef FREQ_SCHED_DUTY_EN
  logic [N_CH-1:0] lvl, fall;
`endif
  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    sq_edge_sync u_sync (
      .ref_clk(ref_clk),
      .rst_n  (rst_n),
      .d      (sq_wave[i]),
`ifdef FREQ_SCHED_DUTY_EN
      .level  (lvl[i]),
      .fall   (fall[i]),
`else
      .level  (),
      .fall   (),
`endif
      .rise   (rise[i])
    );
  end
  assign sel_rise  = rise[ptr];
  assign tmo       = tcnt == TO_LAST;
  assign res_valid = state == REPORT;
  assign hs        = res_valid && res_ready;
  // next pointer is the lowest set bit of the incoming mask in IDLE, else of what is left after this result
  always_comb begin
    mask_left = mask & ~(N_CH'(1) << ptr);
    pick_src  = (state == IDLE) ? ch_enable : mask_left;
    nxt_ptr   = '0;
    for (int i = N_CH - 1; i >= 0; i--) nxt_ptr = pick_src[i] ? CH_W'(i) : nxt_ptr;
  end
  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      mask        <= '0;
      ptr         <= '0;
      pcnt        <= '0;
      tcnt        <= '0;
      res_ch      <= '0;
      res_period  <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && |ch_enable) begin
          mask  <= ch_enable;
          busy  <= 1'b1;
          ptr   <= nxt_ptr;
          state <= SELECT;
        end
        SELECT: begin
          tcnt  <= '0;
          state <= ARM;
        end
        ARM: if (tmo) begin
          res_ch      <= ptr;
          res_period  <= '0;
          res_timeout <= 1'b1;
          state       <= REPORT;
        end else begin
          tcnt <= tcnt + 1'b1;
          if (sel_rise) begin
            pcnt  <= '0;
            state <= MEASURE;
          end
        end
        MEASURE: if (tmo) begin
          res_ch      <= ptr;
          res_period  <= '0;
          res_timeout <= 1'b1;
          state       <= REPORT;
        end else begin
          tcnt <= tcnt + 1'b1;
          pcnt <= pcnt + 1'b1;
          if (sel_rise) begin
            res_ch      <= ptr;
            res_period  <= pcnt + 1'b1;
            res_timeout <= 1'b0;
            state       <= REPORT;
          end
        end
        REPORT: if (hs) begin
          mask <= mask_left;
          if (|mask_left) begin
            ptr   <= nxt_ptr;
            state <= SELECT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef FREQ_SCHED_DUTY_EN
  logic [CNT_W-1:0] hcnt;
  logic hrun;
  // arming cycle already has the level high, so the count starts at 1
  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      hcnt     <= '0;
      hrun     <= 1'b0;
      res_high <= '0;
    end else begin
      if (state == ARM && sel_rise && !tmo) begin
        hcnt <= CNT_W'(1);
        hrun <= 1'b1;
      end else if (state == MEASURE && hrun) begin
        hrun <= ~fall[ptr];
        hcnt <= (lvl[ptr] && !fall[ptr]) ? hcnt + 1'b1 : hcnt;
      end
      if ((state == ARM || state == MEASURE) && tmo) res_high <= '0;
      else if (state == MEASURE && sel_rise) res_high <= hcnt;
    end
  end
`endif
endmodule
